// File: rtl/fault_monitor.sv
// Per-channel opcode/control sanity checker with a debounced OK/SUSPECT/FAULT
// escalation FSM, sticky per-channel flags and a saturating fault counter.
module fault_monitor #(
    parameter int NUM_CH = 2,
    parameter int THRESH = 3,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ch_valid,
    input  logic [7*NUM_CH-1:0]   opcode,
    input  logic [NUM_CH-1:0]     mem_read,
    input  logic [NUM_CH-1:0]     mem_write,
    input  logic [NUM_CH-1:0]     reg_write,
    input  logic                  fault_ack,
    output logic [NUM_CH-1:0]     fault_detected,
    output logic [NUM_CH-1:0]     ch_sticky,
    output logic                  fault_irq,
    output logic [1:0]            fault_state,
    output logic [2:0]            fault_ch,
    output logic [1:0]            fault_cause,
    output logic [CNT_W-1:0]      fault_count
);

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_FAULT   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_CONFLICT = 2'b10;
    localparam logic [1:0] CAUSE_NOACT    = 2'b11;

    state_e              state_q, state_d;
    logic [3:0]          run_q, run_d;
    logic [3:0]          run_inc;
    logic [2:0]          cap_ch_q, cap_ch_d;
    logic [1:0]          cap_cause_q, cap_cause_d;
    logic [NUM_CH-1:0]   sticky_q, sticky_d;
    logic [NUM_CH-1:0]   det_q, det_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_CH-1:0]   ch_fault;
    logic [2*NUM_CH-1:0] ch_cause;
    logic                any_fault;
    logic                first_hit;
    logic [2:0]          first_ch;
    logic [1:0]          first_cause;
    logic                ack_clear;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011:
                is_legal = 1'b1;
            default:
                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] decode_cause(input logic       valid,
                                                input logic [6:0] op,
                                                input logic       mr,
                                                input logic       mw,
                                                input logic       rw);
        decode_cause = CAUSE_NONE;
        if (valid) begin
            if (!is_legal(op)) begin
                decode_cause = CAUSE_ILLEGAL;
            end else if (mr && mw) begin
                decode_cause = CAUSE_CONFLICT;
            end else if (!mr && !mw && !rw &&
                         op != 7'b1100011 && op != 7'b1110011) begin
                // Branches and system ops legitimately touch neither memory nor registers.
                decode_cause = CAUSE_NOACT;
            end
        end
    endfunction

    always_comb begin
        ch_fault = '0;
        ch_cause = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_cause[2*i +: 2] = decode_cause(ch_valid[i], opcode[7*i +: 7],
                                              mem_read[i], mem_write[i], reg_write[i]);
            ch_fault[i] = (ch_cause[2*i +: 2] != CAUSE_NONE);
        end
    end

    assign any_fault = |ch_fault;

    always_comb begin
        first_hit   = 1'b0;
        first_ch    = '0;
        first_cause = CAUSE_NONE;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!first_hit && ch_fault[i]) begin
                first_hit   = 1'b1;
                first_ch    = 3'(i);
                first_cause = ch_cause[2*i +: 2];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OK;
        end else begin
            state_q <= state_d;
        end
    end

    assign run_inc = run_q + 4'd1;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OK: begin
                if (any_fault) begin
                    state_d = (THRESH == 1) ? ST_FAULT : ST_SUSPECT;
                end
            end
            ST_SUSPECT: begin
                if (any_fault) begin
                    if (run_inc >= 4'(THRESH)) begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    state_d = ST_OK;
                end
            end
            ST_FAULT: begin
                if (fault_ack) begin
                    state_d = ST_OK;
                end
            end
            default: state_d = ST_OK;
        endcase
    end

    assign ack_clear = (state_q == ST_FAULT) && fault_ack;

    always_comb begin
        run_d       = run_q;
        cap_ch_d    = cap_ch_q;
        cap_cause_d = cap_cause_q;
        det_d       = ch_fault;
        // New faults re-set their sticky bit even in the cycle an ack clears the rest.
        sticky_d    = (ack_clear ? '0 : sticky_q) | ch_fault;
        cnt_d       = (any_fault && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        case (state_q)
            ST_OK: begin
                if (any_fault) begin
                    run_d       = 4'd1;
                    cap_ch_d    = first_ch;
                    cap_cause_d = first_cause;
                end
            end
            ST_SUSPECT: begin
                if (any_fault) begin
                    run_d = run_inc;
                end else begin
                    run_d       = '0;
                    cap_ch_d    = '0;
                    cap_cause_d = CAUSE_NONE;
                end
            end
            ST_FAULT: begin
                if (fault_ack) begin
                    run_d       = '0;
                    cap_ch_d    = '0;
                    cap_cause_d = CAUSE_NONE;
                end
            end
            default: begin
                run_d       = '0;
                cap_ch_d    = '0;
                cap_cause_d = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= '0;
            cap_ch_q    <= '0;
            cap_cause_q <= '0;
            sticky_q    <= '0;
            det_q       <= '0;
            cnt_q       <= '0;
        end else begin
            run_q       <= run_d;
            cap_ch_q    <= cap_ch_d;
            cap_cause_q <= cap_cause_d;
            sticky_q    <= sticky_d;
            det_q       <= det_d;
            cnt_q       <= cnt_d;
        end
    end

    // Output logic
    always_comb begin
        fault_irq      = (state_q == ST_FAULT);
        fault_state    = state_q;
        fault_ch       = cap_ch_q;
        fault_cause    = cap_cause_q;
        fault_detected = det_q;
        ch_sticky      = sticky_q;
        fault_count    = cnt_q;
    end

endmodule

// File: tb/tb_fault_monitor.sv
// Scoreboard bench for fault_monitor: default instance plus a THRESH=1, CNT_W=2
// instance sharing the same stimulus.
module tb_fault_monitor;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ch_valid;
    logic [13:0] opcode;
    logic [1:0]  mem_read, mem_write, reg_write;
    logic        fault_ack;

    logic [1:0]  fd_a, st_a, state_a, cause_a;
    logic        irq_a;
    logic [2:0]  ch_a;
    logic [7:0]  cnt_a;
    logic [1:0]  fd_b, st_b, state_b, cause_b;
    logic        irq_b;
    logic [2:0]  ch_b;
    logic [1:0]  cnt_b;

    fault_monitor #(.NUM_CH(2), .THRESH(3), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .opcode(opcode),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .fault_ack(fault_ack), .fault_detected(fd_a), .ch_sticky(st_a),
        .fault_irq(irq_a), .fault_state(state_a), .fault_ch(ch_a),
        .fault_cause(cause_a), .fault_count(cnt_a)
    );

    fault_monitor #(.NUM_CH(2), .THRESH(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .opcode(opcode),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .fault_ack(fault_ack), .fault_detected(fd_b), .ch_sticky(st_b),
        .fault_irq(irq_b), .fault_state(state_b), .fault_ch(ch_b),
        .fault_cause(cause_b), .fault_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] det;
        logic [1:0] sticky;
        logic       irq;
        logic [1:0] st;
        logic [2:0] ch;
        logic [1:0] cause;
        logic [7:0] cnt;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } vec_t;

    vec_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state per instance (0: THRESH=3/CNT_W=8, 1: THRESH=1/CNT_W=2)
    int m_st[2], m_run[2], m_ch[2], m_cause[2], m_sticky[2], m_det[2], m_cnt[2];
    int m_thr[2]  = '{3, 1};
    int m_cmax[2] = '{255, 3};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_cause(input logic v, input logic [6:0] op,
                                             input logic mr, input logic mw, input logic rw);
        logic legal;
        legal = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
        if (!v) return 2'b00;
        if (!legal) return 2'b01;
        if (mr && mw) return 2'b10;
        if (!mr && !mw && !rw && op != 7'b1100011 && op != 7'b1110011) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_run[k] = 0; m_ch[k] = 0; m_cause[k] = 0;
            m_sticky[k] = 0; m_det[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [1:0] c0, input logic [1:0] c1,
                              input logic ack);
        int  flt;
        bit  anyf;
        int  lch;
        int  lcz;
        flt  = ((c1 != 2'b00) ? 2 : 0) + ((c0 != 2'b00) ? 1 : 0);
        anyf = (flt != 0);
        lch  = (c0 != 2'b00) ? 0 : 1;
        lcz  = (c0 != 2'b00) ? int'(c0) : int'(c1);
        m_sticky[k] = (((m_st[k] == 2) && ack) ? 0 : m_sticky[k]) | flt;
        m_det[k] = flt;
        if (anyf && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
        case (m_st[k])
            0: if (anyf) begin
                m_run[k] = 1; m_ch[k] = lch; m_cause[k] = lcz;
                m_st[k] = (m_thr[k] == 1) ? 2 : 1;
            end
            1: if (anyf) begin
                m_run[k]++;
                if (m_run[k] >= m_thr[k]) m_st[k] = 2;
            end else begin
                m_st[k] = 0; m_run[k] = 0; m_ch[k] = 0; m_cause[k] = 0;
            end
            default: if (ack) begin
                m_st[k] = 0; m_run[k] = 0; m_ch[k] = 0; m_cause[k] = 0;
            end
        endcase
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t o;
        o.det    = 2'(m_det[k]);
        o.sticky = 2'(m_sticky[k]);
        o.irq    = (m_st[k] == 2);
        o.st     = 2'(m_st[k]);
        o.ch     = 3'(m_ch[k]);
        o.cause  = 2'(m_cause[k]);
        o.cnt    = 8'(m_cnt[k]);
        return o;
    endfunction

    task automatic compare_vec(input vec_t e);
        check_eq("a.det",    32'(fd_a),    32'(e.a.det));
        check_eq("a.sticky", 32'(st_a),    32'(e.a.sticky));
        check_eq("a.irq",    32'(irq_a),   32'(e.a.irq));
        check_eq("a.state",  32'(state_a), 32'(e.a.st));
        check_eq("a.ch",     32'(ch_a),    32'(e.a.ch));
        check_eq("a.cause",  32'(cause_a), 32'(e.a.cause));
        check_eq("a.count",  32'(cnt_a),   32'(e.a.cnt));
        check_eq("b.det",    32'(fd_b),    32'(e.b.det));
        check_eq("b.sticky", 32'(st_b),    32'(e.b.sticky));
        check_eq("b.irq",    32'(irq_b),   32'(e.b.irq));
        check_eq("b.state",  32'(state_b), 32'(e.b.st));
        check_eq("b.ch",     32'(ch_b),    32'(e.b.ch));
        check_eq("b.cause",  32'(cause_b), 32'(e.b.cause));
        check_eq("b.count",  32'(cnt_b),   32'(e.b.cnt));
    endtask

    task automatic drive(input logic [1:0] v, input logic [6:0] o0, input logic [6:0] o1,
                         input logic [1:0] mr, input logic [1:0] mw, input logic [1:0] rw,
                         input logic ack);
        logic [1:0] c0, c1;
        vec_t       e;
        ch_valid  = v;
        opcode    = {o1, o0};
        mem_read  = mr;
        mem_write = mw;
        reg_write = rw;
        fault_ack = ack;
        c0 = ref_cause(v[0], o0, mr[0], mw[0], rw[0]);
        c1 = ref_cause(v[1], o1, mr[1], mw[1], rw[1]);
        model_step(0, c0, c1, ack);
        model_step(1, c0, c1, ack);
        e.a = model_obs(0);
        e.b = model_obs(1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            compare_vec(sb_q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 7'h33, 7'h33, 2'b00, 2'b00, 2'b01, 1'b0);
    endtask

    task automatic check_reset_now();
        vec_t e;
        model_reset();
        e.a = model_obs(0);
        e.b = model_obs(1);
        compare_vec(e);
    endtask

    logic [6:0] optab[13] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                              7'h37, 7'h17, 7'h73, 7'h7F, 7'h00, 7'h0B};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ch_valid = '0; opcode = '0;
        mem_read = '0; mem_write = '0; reg_write = '0; fault_ack = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset_now();
        rst_n = 1'b1;

        // Clean traffic on channel 0
        for (int i = 0; i < 10; i++) drive(2'b01, 7'h33, 7'h00, 2'b00, 2'b00, 2'b01, 1'b0);
        check_eq("clean count", 32'(cnt_a), 32'd0);
        check_eq("clean state", 32'(state_a), 32'd0);

        // Channel 1 illegal opcode escalates to FAULT on the third cycle
        for (int i = 0; i < 3; i++) drive(2'b10, 7'h00, 7'h7F, 2'b00, 2'b00, 2'b00, 1'b0);
        check_eq("illegal state", 32'(state_a), 32'd2);
        check_eq("illegal irq",   32'(irq_a),   32'd1);
        check_eq("illegal ch",    32'(ch_a),    32'd1);
        check_eq("illegal cause", 32'(cause_a), 32'd1);
        check_eq("illegal stick", 32'(st_a),    32'd2);
        check_eq("illegal count", 32'(cnt_a),   32'd3);
        check_eq("b saturated",   32'(cnt_b),   32'd3);
        drive(2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 1'b1);
        check_eq("ack sticky", 32'(st_a), 32'd0);
        idle(1);

        // Read/write conflict for two cycles then clean: SUSPECT and back
        for (int i = 0; i < 2; i++) drive(2'b01, 7'h03, 7'h00, 2'b11, 2'b11, 2'b00, 1'b0);
        check_eq("conflict cause", 32'(cause_a), 32'd2);
        drive(2'b01, 7'h33, 7'h00, 2'b00, 2'b00, 2'b01, 1'b0);
        check_eq("conflict state", 32'(state_a), 32'd0);
        check_eq("conflict clr",   32'(cause_a), 32'd0);
        check_eq("conflict stick", 32'(st_a),    32'd1);
        drive(2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 1'b1);

        // Both channels faulting: lowest channel wins the capture
        for (int i = 0; i < 3; i++) drive(2'b11, 7'h23, 7'h7F, 2'b00, 2'b00, 2'b00, 1'b0);
        check_eq("dual ch",    32'(ch_a),    32'd0);
        check_eq("dual cause", 32'(cause_a), 32'd3);
        drive(2'b11, 7'h23, 7'h7F, 2'b00, 2'b00, 2'b00, 1'b1);
        check_eq("ackfault state", 32'(state_a), 32'd0);
        check_eq("ackfault stick", 32'(st_a),    32'd3);
        drive(2'b10, 7'h00, 7'h0B, 2'b00, 2'b00, 2'b00, 1'b0);
        idle(2);

        // Ack is ignored outside FAULT
        drive(2'b01, 7'h7F, 7'h00, 2'b00, 2'b00, 2'b00, 1'b1);
        drive(2'b01, 7'h7F, 7'h00, 2'b00, 2'b00, 2'b00, 1'b1);
        check_eq("ack in suspect", 32'(state_a), 32'd1);
        idle(2);
        drive(2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 1'b1);

        // Exempt opcodes with no controls are not faults
        drive(2'b11, 7'h63, 7'h73, 2'b00, 2'b00, 2'b00, 1'b0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            logic [1:0] v, mr, mw, rw;
            logic       ack;
            logic [6:0] o0, o1;
            v   = 2'($urandom_range(0, 3));
            mr  = 2'($urandom_range(0, 3));
            mw  = 2'($urandom_range(0, 3));
            rw  = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 3) == 0);
            o0  = optab[$urandom_range(0, 12)];
            o1  = optab[$urandom_range(0, 12)];
            drive(v, o0, o1, mr, mw, rw, ack);
        end
        drive(2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 1'b1);

        // Asynchronous reset in the middle of FAULT
        for (int i = 0; i < 3; i++) drive(2'b10, 7'h00, 7'h7F, 2'b00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_now();
        check_eq("rst irq", 32'(irq_a), 32'd0);
        @(posedge clk); #1;
        check_reset_now();
        rst_n = 1'b1;
        drive(2'b01, 7'h03, 7'h00, 2'b11, 2'b11, 2'b00, 1'b0);
        check_eq("post-rst state", 32'(state_a), 32'd1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fault_monitor.md
FAULT_MONITOR -- requirements
Module: fault_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of independently checked decode channels (1..8).
REQ-002 SHALL have parameter THRESH, default 3, meaning consecutive faulty cycles before a fault is declared (1..15).
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of the saturating total-fault counter.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ch_valid  input  NUM_CH  per-channel check enable.
REQ-007 opcode  input  7*NUM_CH  channel i at bits [7i+6:7i].
REQ-008 mem_read, mem_write, reg_write  input  NUM_CH each  per-channel control bits.
REQ-009 fault_ack  input  1  software acknowledge, level-sampled.
REQ-010 fault_detected  output  NUM_CH  registered per-channel fault flag of the previous cycle.
REQ-011 ch_sticky  output  NUM_CH  per-channel sticky fault flag, cleared only by acknowledge.
REQ-012 fault_irq  output  1  high while state is FAULT.
REQ-013 fault_state  output  2  00 OK, 01 SUSPECT, 10 FAULT.
REQ-014 fault_ch  output  3  channel index of the first fault captured on the OK->SUSPECT transition.
REQ-015 fault_cause  output  2  01 illegal opcode, 10 read/write conflict, 11 no action.
REQ-016 fault_count  output  CNT_W  saturating count of cycles in which any channel faulted.

Function
REQ-017 Legal opcodes SHALL be 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
REQ-018 A channel SHALL fault only when ch_valid=1; cause priority SHALL be illegal opcode > mem_read&mem_write conflict > no action.
REQ-019 No action SHALL mean legal opcode with mem_read=mem_write=reg_write=0, excluding 1100011 and 1110011.
REQ-020 fault_detected[i] SHALL register channel i's fault one cycle after the sampled inputs (latency 1).
REQ-021 any_fault SHALL be the OR of the combinational channel faults in the current cycle.
REQ-022 The capture priority SHALL be the lowest-indexed faulting channel and its cause.
REQ-023 OK state: on any_fault, SHALL go to SUSPECT, set run counter to 1, and capture fault_ch/fault_cause; if THRESH=1, SHALL go directly to FAULT.
REQ-024 SUSPECT state: any_fault SHALL increment run counter; reaching THRESH SHALL enter FAULT; a fault-free cycle SHALL return to OK and clear the run counter.
REQ-025 FAULT state: SHALL hold fault_irq=1 and capture registers until fault_ack=1, then SHALL go to OK next cycle and clear ch_sticky, fault_ch, fault_cause and the run counter.
REQ-026 When fault_ack and any_fault coincide in FAULT, ack SHALL win; the new fault SHALL still set ch_sticky and count, and SHALL be re-evaluated from OK on the next cycle.
REQ-027 fault_ack in OK or SUSPECT SHALL be ignored.
REQ-028 ch_sticky[i] SHALL set on any fault of channel i in any state; set SHALL take priority over the ack clear in the same cycle.
REQ-029 fault_count SHALL increment by 1 per any_fault cycle regardless of channel count, saturating at 2^CNT_W-1 with no wrap.
REQ-030 fault_count SHALL be cleared only by reset.
REQ-031 Encoding 11 of fault_state SHALL be unreachable; if entered, the block SHALL recover to OK next cycle.

Reset
REQ-032 While rst_n=0, all outputs SHALL be 0, state SHALL be OK, and run counter SHALL be 0, asynchronously.
REQ-033 Reset asserted mid-SUSPECT or mid-FAULT SHALL discard all capture; the first clk edge after deassertion SHALL sample normally.

Verification
REQ-034 Ch0 0110011/reg_write=1 valid for 10 cycles -> fault_state stays 00, fault_count=0, fault_detected=00.
REQ-035 Ch1 opcode 1111111 for 3 cycles (THRESH=3) -> SUSPECT then FAULT on the 3rd cycle edge, fault_irq=1, fault_ch=1, fault_cause=01, ch_sticky=10, fault_count=3.
REQ-036 Ch0 0000011 with mem_read=mem_write=1 for 2 cycles, then clean -> SUSPECT then OK, fault_irq never 1, fault_cause=10 captured then cleared, ch_sticky=01 persists.
REQ-037 Both channels faulting (ch0 0100011 no action, ch1 illegal) -> fault_ch=0, fault_cause=11, fault_count +1 per cycle; in FAULT, ack plus new fault -> OK next cycle, ch_sticky remains set.
REQ-038 CNT_W=2, 5 faulty cycles -> fault_count saturates at 3.
REQ-039 rst_n low during FAULT -> all outputs 0 immediately, fault_state=00.
